regs_wb_arbiter: RTL

REGS_WB_ARBITER -- requirements
Module: regs_wb_arbiter

---
 rtl/yadan_defs.sv | 15 +
 rtl/regs_wb_skid.sv | 43 ++++
 rtl/regs_wb_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/yadan_defs.sv
// Shared definitions for the register-file write arbitration slice.
// Holds the debug FSM encoding and default address/data widths.
package yadan_defs;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DBG_WR  = 2'd1,
    DBG_RD  = 2'd2,
    DBG_ACK = 2'd3
  } dbg_state_e;

endpackage

// File: rtl/regs_wb_skid.sv
// One-entry holding buffer for a divider result that lost the write port.
// Ports: i_load/i_addr/i_data fill it, i_drain empties it, o_* show contents.
module regs_wb_skid
  import yadan_defs::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic          i_drain,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  // Load only happens while empty, so load and drain never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_data  <= i_data;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;

endmodule

// File: rtl/regs_wb_arbiter.sv
// Register-file write-port arbiter: writeback > divider > debug write,
// plus a debug read/write FSM sharing read port 2 with decode.
// Ports: wb_* writeback, div_* divider offer/pending, dbg_* debug access,
// id_* decode read request, rf_* register-file write and read port 2.
module regs_wb_arbiter
  import yadan_defs::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_waddr_i,
  input  logic [DW-1:0] wb_wdata_i,
  input  logic          div_valid_i,
  input  logic [AW-1:0] div_waddr_i,
  input  logic [DW-1:0] div_wdata_i,
  output logic          div_ready_o,
  output logic          div_pend_o,
  output logic [AW-1:0] div_pend_addr_o,
  input  logic          halted_i,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic          dbg_ack_o,
  output logic [DW-1:0] dbg_rdata_o,
  input  logic          id_re2_i,
  input  logic [AW-1:0] id_raddr2_i,
  input  logic [DW-1:0] rf_rdata2_i,
  output logic          rf_we_o,
  output logic [AW-1:0] rf_waddr_o,
  output logic [DW-1:0] rf_wdata_o,
  output logic          rf_re2_o,
  output logic [AW-1:0] rf_raddr2_o
);

  dbg_state_e    r_state;
  dbg_state_e    w_next;
  logic [AW-1:0] r_dbg_addr;
  logic [DW-1:0] r_dbg_wdata;
  logic [DW-1:0] r_rdata;

  logic          w_buf_v;
  logic [AW-1:0] w_buf_addr;
  logic [DW-1:0] w_buf_data;

  logic w_wb_wr;
  logic w_div_acc;
  logic w_div_nz;
  logic w_div_wr;
  logic w_buf_load;
  logic w_buf_drain;
  logic w_port_free;
  logic w_dbg_start;
  logic w_dbg_wr;
  logic w_dbg_rd;
  logic w_sel_dbg;
  logic w_we;

  // x0 writes never occupy the port; they are simply dropped.
  assign w_wb_wr   = wb_we_i && (wb_waddr_i != '0);
  assign w_div_acc = div_valid_i && !w_buf_v;
  assign w_div_nz  = div_waddr_i != '0;

  assign w_div_wr    = w_div_acc && w_div_nz && !w_wb_wr;
  assign w_buf_load  = w_div_acc && w_div_nz && w_wb_wr && !rst;
  assign w_buf_drain = w_buf_v && !w_wb_wr;
  assign w_port_free = !w_wb_wr && !w_buf_v && !w_div_wr;

  regs_wb_skid #(
    .AW (AW),
    .DW (DW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_addr  (div_waddr_i),
    .i_data  (div_wdata_i),
    .i_drain (w_buf_drain),
    .o_valid (w_buf_v),
    .o_addr  (w_buf_addr),
    .o_data  (w_buf_data)
  );

  assign div_ready_o     = !w_buf_v;
  assign div_pend_o      = w_buf_v;
  assign div_pend_addr_o = w_buf_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // halted_i is only consulted when starting, so a started
  // transaction always runs to its ack.
  always_comb begin
    w_next      = r_state;
    w_dbg_start = 1'b0;
    w_dbg_wr    = 1'b0;
    w_dbg_rd    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (dbg_req_i && halted_i) begin
          w_dbg_start = 1'b1;
          w_next      = dbg_we_i ? DBG_WR : DBG_RD;
        end
      end
      DBG_WR: begin
        if (w_port_free) begin
          w_dbg_wr = 1'b1;
          w_next   = DBG_ACK;
        end
      end
      DBG_RD: begin
        w_dbg_rd = 1'b1;
        w_next   = DBG_ACK;
      end
      DBG_ACK: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dbg_addr  <= '0;
      r_dbg_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      if (w_dbg_start) begin
        r_dbg_addr  <= dbg_addr_i;
        r_dbg_wdata <= dbg_wdata_i;
      end
      if (w_dbg_rd) begin
        r_rdata <= (r_dbg_addr == '0) ? '0 : rf_rdata2_i;
      end
    end
  end

  assign w_sel_dbg = w_dbg_wr && (r_dbg_addr != '0);

  // Select terms are mutually exclusive by construction.
  always_comb begin
    w_we       = 1'b0;
    rf_waddr_o = wb_waddr_i;
    rf_wdata_o = wb_wdata_i;
    unique case (1'b1)
      w_wb_wr: begin
        w_we = 1'b1;
      end
      w_buf_drain: begin
        w_we       = 1'b1;
        rf_waddr_o = w_buf_addr;
        rf_wdata_o = w_buf_data;
      end
      w_div_wr: begin
        w_we       = 1'b1;
        rf_waddr_o = div_waddr_i;
        rf_wdata_o = div_wdata_i;
      end
      w_sel_dbg: begin
        w_we       = 1'b1;
        rf_waddr_o = r_dbg_addr;
        rf_wdata_o = r_dbg_wdata;
      end
      default: begin
        w_we = 1'b0;
      end
    endcase
  end

  assign rf_we_o = w_we && !rst;

  assign rf_re2_o    = w_dbg_rd ? 1'b1 : id_re2_i;
  assign rf_raddr2_o = w_dbg_rd ? r_dbg_addr : id_raddr2_i;

  assign dbg_ack_o   = (r_state == DBG_ACK);
  assign dbg_rdata_o = r_rdata;

endmodule
